// File: rtl/f1_light_seq.sv
// Formula-1 style start-light sequencer: fills the lights one per tick, requests an
// external random delay, then blanks all lights and pulses go.
module f1_light_seq #(
    parameter int N_LIGHTS = 8,
    parameter int FILL_MSB = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                delay_done,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                go
);

    localparam int CW = $clog2(N_LIGHTS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_LIGHTS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEQ   = 3'd1,
        DREQ  = 3'd2,
        DWAIT = 3'd3,
        GO    = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = trigger ? SEQ : IDLE;
            SEQ:     state_nxt = (en && count == CNT_MAX) ? DREQ : SEQ;
            DREQ:    state_nxt = DWAIT;
            DWAIT:   state_nxt = delay_done ? GO : DWAIT;
            GO:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_seq   = 1'b0;
        cmd_delay = 1'b0;
        go        = 1'b0;
        case (state)
            SEQ:     cmd_seq   = 1'b1;
            DREQ:    cmd_delay = 1'b1;
            GO:      go        = 1'b1;
            default: ;
        endcase
    end

    // The count is cleared on the way into GO so the lights are already dark during the go pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case (state)
                SEQ: begin
                    if (en && count < CNT_MAX) begin
                        count <= count + CW'(1);
                    end
                end
                DREQ:    count <= count;
                DWAIT:   count <= delay_done ? '0 : count;
                default: count <= '0;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N_LIGHTS; i++) begin
            if (FILL_MSB != 0) begin
                data_out[i] = (i >= N_LIGHTS - int'(count));
            end else begin
                data_out[i] = (i < int'(count));
            end
        end
    end

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: three configurations share one stimulus stream and are
// checked every cycle against a phase/lit-count model, plus literal sequences.
module tb_f1_light_seq;

    localparam int W = 32;
    localparam int PH_IDLE = 0, PH_FILL = 1, PH_REQ = 2, PH_WAIT = 3, PH_GO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en = 1'b0, trigger = 1'b0, delay_done = 1'b0;
    logic [7:0] d8;
    logic [3:0] d4;
    logic [0:0] d1;
    logic [2:0] cs, cd, gg;

    int  checks = 0;
    int  errors = 0;
    bit  chk_on = 1'b0;

    f1_light_seq #(.N_LIGHTS(8), .FILL_MSB(0)) u_n8 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .delay_done(delay_done),
        .data_out(d8), .cmd_seq(cs[0]), .cmd_delay(cd[0]), .go(gg[0]));

    f1_light_seq #(.N_LIGHTS(4), .FILL_MSB(1)) u_n4 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .delay_done(delay_done),
        .data_out(d4), .cmd_seq(cs[1]), .cmd_delay(cd[1]), .go(gg[1]));

    f1_light_seq #(.N_LIGHTS(1), .FILL_MSB(0)) u_n1 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .delay_done(delay_done),
        .data_out(d1), .cmd_seq(cs[2]), .cmd_delay(cd[2]), .go(gg[2]));

    // ---------------- reference model ----------------
    int nl[3] = '{8, 4, 1};
    int fm[3] = '{0, 1, 0};
    int ph[3] = '{PH_IDLE, PH_IDLE, PH_IDLE};
    int lit[3] = '{0, 0, 0};

    function automatic logic [W-1:0] pattern(int n, int f, int l);
        logic [63:0] ones;
        ones = (64'd1 << l) - 64'd1;
        if (f != 0) return W'(ones << (n - l));
        return W'(ones);
    endfunction

    function automatic logic [W-1:0] got_data(int k);
        case (k)
            0:       return W'(d8);
            1:       return W'(d4);
            default: return W'(d1);
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                ph[k] = PH_IDLE;
                lit[k] = 0;
            end else begin
                case (ph[k])
                    PH_IDLE: if (trigger) ph[k] = PH_FILL;
                    PH_FILL: if (en) begin
                        if (lit[k] < nl[k]) lit[k] = lit[k] + 1;
                        else ph[k] = PH_REQ;
                    end
                    PH_REQ:  ph[k] = PH_WAIT;
                    PH_WAIT: if (delay_done) begin
                        ph[k] = PH_GO;
                        lit[k] = 0;
                    end
                    default: begin
                        ph[k] = PH_IDLE;
                        lit[k] = 0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("data_out[%0d]", k), got_data(k), pattern(nl[k], fm[k], lit[k]));
                chk($sformatf("cmd_seq[%0d]", k), W'(cs[k]), W'(ph[k] == PH_FILL));
                chk($sformatf("cmd_delay[%0d]", k), W'(cd[k]), W'(ph[k] == PH_REQ));
                chk($sformatf("go[%0d]", k), W'(gg[k]), W'(ph[k] == PH_GO));
            end
        end
    end

    // ---------------- driver ----------------
    // Inputs change just after a falling edge; outputs read after return reflect that posedge.
    task automatic step(input logic r, input logic e, input logic t, input logic d);
        rst = r; en = e; trigger = t; delay_done = d;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_quiet(input string name);
        chk({name, "_d8"}, W'(d8), '0);
        chk({name, "_d4"}, W'(d4), '0);
        chk({name, "_d1"}, W'(d1), '0);
        chk({name, "_cmds"}, W'({cs, cd, gg}), '0);
    endtask

    // Full sequence with en=1, optionally with ignored trigger/delay_done pulses.
    task automatic run_seq(input bit noise);
        logic [W-1:0] exp0_q[$];
        logic [W-1:0] exp1_q[$];
        logic [W-1:0] exp2_q[$];
        bit [2:0] cd_seen;
        logic t, d;
        exp0_q = '{32'h00, 32'h01, 32'h03, 32'h07, 32'h0F, 32'h1F, 32'h3F, 32'h7F, 32'hFF};
        exp1_q = '{32'h0, 32'h8, 32'hC, 32'hE, 32'hF};
        exp2_q = '{32'h0, 32'h1};
        cd_seen = '0;
        for (int i = 0; i < 20; i++) begin
            t = (i == 0) || (noise && (i == 4 || i == 11));
            d = (i == 14) || (noise && (i == 4 || i == 10));
            step(1'b0, 1'b1, t, d);
            if (exp0_q.size() > 0) chk("seq_lit_n8", W'(d8), exp0_q.pop_front());
            else if (!cd_seen[0]) begin chk("cmd_delay_n8", W'(cd[0]), 1); cd_seen[0] = 1'b1; end
            if (exp1_q.size() > 0) chk("seq_lit_n4msb", W'(d4), exp1_q.pop_front());
            else if (!cd_seen[1]) begin chk("cmd_delay_n4msb", W'(cd[1]), 1); cd_seen[1] = 1'b1; end
            if (exp2_q.size() > 0) chk("seq_lit_n1", W'(d1), exp2_q.pop_front());
            else if (!cd_seen[2]) begin chk("cmd_delay_n1", W'(cd[2]), 1); cd_seen[2] = 1'b1; end
            if (i >= 10 && i <= 13) chk("dwait_hold_n8", W'(d8), 32'hFF);
            if (i == 14) chk("go_pulse_n8", W'({gg[0], d8}), 32'h100);
            if (i == 15) chk("back_idle_n8", W'({gg[0], cs[0], d8}), 0);
        end
    endtask

    // en every third cycle: each intermediate light pattern must last exactly 3 cycles.
    task automatic run_slow_en();
        logic [7:0] prev;
        int runlen;
        prev = 8'h00;
        runlen = 0;
        for (int i = 0; i < 45; i++) begin
            step(1'b0, (i % 3) == 2, i == 0, i == 40);
            if (d8 == prev) runlen++;
            else begin
                if (prev != 8'h00 && prev != 8'hFF) chk("slow_hold_len", W'(runlen), 3);
                prev = d8;
                runlen = 1;
            end
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_on = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_all_quiet("reset");

        // trigger accepted on the very first cycle after reset
        run_seq(1'b0);
        run_seq(1'b1);
        run_slow_en();

        // reset mid-fill, at 0F on the 8-light instance
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_fill_0f", W'(d8), 32'h0F);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_all_quiet("rst_in_fill");

        // reset while waiting for the delay
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("in_dwait_ff", W'({cs[0], cd[0], d8}), 32'hFF);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk_all_quiet("rst_in_dwait");
        run_seq(1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
